// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the external byte-serial bus sequencer.
package ext_bus_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A0,
    ST_A1,
    ST_A2,
    ST_A3,
    ST_TURN,
    ST_R0,
    ST_R1,
    ST_R2,
    ST_R3,
    ST_DONE
  } seq_state_e;

  // Byte k of a 32-bit word, least significant byte first.
  function automatic logic [BYTE_W-1:0] byte_lane(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        k);
    return word[{k, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer moves only on accept.
module rr_arb2 #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1 = requester 1 was served last, so requester 0 wins the next tie.
  logic last_q;

  // Grant decode: lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Remember the served requester whenever the sequencer takes a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= (RR_INIT == 0);
    end else if (accept_i) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/ext_bus_sequencer.sv
// Arbitrates two word requesters onto an 8-bit multiplexed pad bus:
// four address bytes, then either done (write) or turnaround plus four
// read bytes. Define SEQ_WAIT_EN to add the ext_wait stall input.
module ext_bus_sequencer
  import ext_bus_pkg::*;
#(
  parameter int unsigned RR_INIT     = 0,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SEQ_WAIT_EN
  input  logic              ext_wait,
`endif
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [WORD_W-1:0] r0_addr,
  input  logic [WORD_W-1:0] r0_wdata,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [WORD_W-1:0] r1_addr,
  input  logic [WORD_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [WORD_W-1:0] rdata,
  output logic [BYTE_W-1:0] pad_addr,
  output logic [BYTE_W-1:0] pad_dout,
  output logic [BYTE_W-1:0] pad_oe,
  input  logic [BYTE_W-1:0] pad_din,
  output logic              busy
);

  seq_state_e              state_q;
  logic [1:0]              turn_cnt_q;
  logic                    gnt_q;      // 1 = requester 1 owns the transfer
  logic                    we_q;
  logic [WORD_W-1:0]       addr_q;
  logic [WORD_W-1:0]       wdata_q;
  logic [3*BYTE_W-1:0]     cap_q;      // bytes 0..2 of the read in flight
  logic [WORD_W-1:0]       rdata_q;
  logic [1:0]              ack_q;
  logic [BYTE_W-1:0]       pad_addr_q;
  logic [BYTE_W-1:0]       pad_dout_q;
  logic [BYTE_W-1:0]       pad_oe_q;

  logic [1:0]              grant;
  logic                    accept;
  logic                    hold_w;
  logic                    win_we;
  logic [WORD_W-1:0]       win_addr;
  logic [WORD_W-1:0]       win_wdata;
  seq_state_e              seq_next;
  logic [1:0]              lane_next;

`ifdef SEQ_WAIT_EN
  assign hold_w = ext_wait;
`else
  assign hold_w = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && (grant != 2'b00);

  rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({r1_req, r0_req}),
    .accept_i (accept),
    .gnt_o    (grant)
  );

  assign win_we    = grant[1] ? r1_we    : r0_we;
  assign win_addr  = grant[1] ? r1_addr  : r0_addr;
  assign win_wdata = grant[1] ? r1_wdata : r0_wdata;

  // Successor state and byte lane for the in-order byte phases.
  always_comb begin
    seq_next  = ST_IDLE;
    lane_next = 2'd0;
    unique case (state_q)
      ST_A0:   begin seq_next = ST_A1; lane_next = 2'd1; end
      ST_A1:   begin seq_next = ST_A2; lane_next = 2'd2; end
      ST_A2:   begin seq_next = ST_A3; lane_next = 2'd3; end
      ST_R0:   seq_next = ST_R1;
      ST_R1:   seq_next = ST_R2;
      ST_R2:   seq_next = ST_R3;
      default: ;
    endcase
  end

  // Sequencer FSM; pad outputs and acks are loaded for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      turn_cnt_q <= 2'd0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= 2'b00;
      pad_addr_q <= '0;
      pad_dout_q <= '0;
      pad_oe_q   <= '0;
    end else begin
      ack_q <= 2'b00;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_A0;
            gnt_q      <= grant[1];
            we_q       <= win_we;
            addr_q     <= win_addr;
            wdata_q    <= win_wdata;
            pad_addr_q <= byte_lane(win_addr, 2'd0);
            pad_dout_q <= win_we ? byte_lane(win_wdata, 2'd0) : '0;
            pad_oe_q   <= {BYTE_W{win_we}};
          end
        end
        ST_A0, ST_A1, ST_A2: begin
          if (!hold_w) begin
            state_q    <= seq_next;
            pad_addr_q <= byte_lane(addr_q, lane_next);
            pad_dout_q <= we_q ? byte_lane(wdata_q, lane_next) : '0;
          end
        end
        ST_A3: begin
          if (!hold_w) begin
            pad_addr_q <= '0;
            pad_dout_q <= '0;
            pad_oe_q   <= '0;
            if (we_q) begin
              state_q <= ST_DONE;
              ack_q   <= {gnt_q, ~gnt_q};
            end else begin
              state_q    <= ST_TURN;
              turn_cnt_q <= 2'(TURN_CYCLES - 1);
            end
          end
        end
        ST_TURN: begin
          if (!hold_w) begin
            if (turn_cnt_q == 2'd0) begin
              state_q <= ST_R0;
            end else begin
              turn_cnt_q <= turn_cnt_q - 2'd1;
            end
          end
        end
        ST_R0, ST_R1, ST_R2: begin
          if (!hold_w) begin
            state_q <= seq_next;
            cap_q   <= {pad_din, cap_q[3*BYTE_W-1:BYTE_W]};
          end
        end
        ST_R3: begin
          if (!hold_w) begin
            state_q <= ST_DONE;
            rdata_q <= {pad_din, cap_q};
            ack_q   <= {gnt_q, ~gnt_q};
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign rdata    = rdata_q;
  assign pad_addr = pad_addr_q;
  assign pad_dout = pad_dout_q;
  assign pad_oe   = pad_oe_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Self-checking bench for ext_bus_sequencer: directed scenarios plus random
// transactions against a transaction-level model of the bus timeline.
module tb_ext_bus_sequencer;

  localparam int TB_RR_INIT = 0;
  localparam int TB_TURN    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_addr = '0, r1_addr = '0, r0_wdata = '0, r1_wdata = '0;
  logic        r0_ack, r1_ack, busy;
  logic [31:0] rdata;
  logic [7:0]  pad_addr, pad_dout, pad_oe;
  logic [7:0]  pad_din = '0;
`ifdef SEQ_WAIT_EN
  logic        ext_wait = 1'b0;
  bit          wait_r1_en = 1'b0;
`endif

  int          total = 0;
  int          bad = 0;
  int          last_served;
  logic [31:0] model_rdata;
  logic [7:0]  din_bytes [4];
  int          obs_winner;
  int          exp_order [4];

  always #5 clk = ~clk;

  ext_bus_sequencer #(
    .RR_INIT     (TB_RR_INIT),
    .TURN_CYCLES (TB_TURN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SEQ_WAIT_EN
    .ext_wait (ext_wait),
`endif
    .r0_req   (r0_req),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_ack   (r0_ack),
    .r1_req   (r1_req),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_ack   (r1_ack),
    .rdata    (rdata),
    .pad_addr (pad_addr),
    .pad_dout (pad_dout),
    .pad_oe   (pad_oe),
    .pad_din  (pad_din),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] e_addr, input logic [7:0] e_dout,
                          input logic [7:0] e_oe, input logic e_busy,
                          input logic e_ack0, input logic e_ack1);
    check({tag, ".pad_addr"}, 32'(pad_addr), 32'(e_addr));
    check({tag, ".pad_dout"}, 32'(pad_dout), 32'(e_dout));
    check({tag, ".pad_oe"},   32'(pad_oe),   32'(e_oe));
    check({tag, ".busy"},     32'(busy),     32'(e_busy));
    check({tag, ".acks"},     32'({r1_ack, r0_ack}), 32'({e_ack1, e_ack0}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bsel(input logic [31:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  // Called one step after an edge with the DUT idle and a request already
  // presented; the next edge is the acceptance edge E.
  task automatic run_one(input bit keep_reqs, input bit drop_mid);
    int          w;
    logic        we;
    logic [31:0] a, d;
    if (r0_req && r1_req) w = (last_served == 0) ? 1 : 0;
    else if (r1_req)      w = 1;
    else                  w = 0;
    last_served = w;
    we = (w == 1) ? r1_we    : r0_we;
    a  = (w == 1) ? r1_addr  : r0_addr;
    d  = (w == 1) ? r1_wdata : r0_wdata;
    step();
    for (int k = 0; k < 4; k++) begin
      chk_outs($sformatf("addr_byte%0d", k), bsel(a, k), we ? bsel(d, k) : 8'h00,
               we ? 8'hFF : 8'h00, 1'b1, 1'b0, 1'b0);
      check("rdata_hold_addr", rdata, model_rdata);
      if (k == 1 && drop_mid) begin
        if (w == 1) r1_req = 1'b0; else r0_req = 1'b0;
      end
      step();
    end
    if (!we) begin
      for (int t = 0; t < TB_TURN; t++) begin
        chk_outs("turn", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        step();
      end
      for (int k = 0; k < 4; k++) begin
        pad_din = din_bytes[k];
        chk_outs($sformatf("read_byte%0d", k), 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        check("rdata_hold_read", rdata, model_rdata);
`ifdef SEQ_WAIT_EN
        if (wait_r1_en && k == 1) begin
          for (int h = 0; h < 3; h++) begin
            ext_wait = 1'b1;
            pad_din  = ~din_bytes[k];
            step();
            chk_outs("wait_hold", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
          end
          ext_wait = 1'b0;
          pad_din  = din_bytes[k];
        end
`endif
        step();
      end
      model_rdata = {din_bytes[3], din_bytes[2], din_bytes[1], din_bytes[0]};
    end
    chk_outs("done", 8'h00, 8'h00, 8'h00, 1'b1, w == 0, w == 1);
    check("rdata_done", rdata, model_rdata);
    obs_winner = r1_ack ? 1 : 0;
    $display("txn: winner=%0d we=%0b addr=%h wdata=%h rdata=%h", w, we, a, d, rdata);
    if (!keep_reqs) begin
      if (w == 1) r1_req = 1'b0; else r0_req = 1'b0;
    end
    step();
    chk_outs("idle_after", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rdata_hold_idle", rdata, model_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    last_served = (TB_RR_INIT == 0) ? 1 : 0;
    model_rdata = '0;
    exp_order   = '{0, 1, 0, 1};

    // Reset state
    #2;
    chk_outs("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_outs("post_reset_idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // r0 write 0x11223344 <- 0xAABBCCDD
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h11223344; r0_wdata = 32'hAABBCCDD;
    run_one(1'b0, 1'b0);
    check("wr_winner", 32'(obs_winner), 32'd0);

    // r1 read, pad bytes 01..04
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'hC0DE0010; r1_wdata = $urandom;
    din_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_one(1'b0, 1'b0);
    check("rd_value", rdata, 32'h04030201);
    check("rd_winner", 32'(obs_winner), 32'd1);

    // Both requests held for four transactions
    r0_req = 1'b1; r0_we = 1'($urandom_range(0, 1)); r0_addr = $urandom; r0_wdata = $urandom;
    r1_req = 1'b1; r1_we = 1'($urandom_range(0, 1)); r1_addr = $urandom; r1_wdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) din_bytes[k] = 8'($urandom_range(0, 255));
      run_one(1'b1, 1'b0);
      check($sformatf("tie_order%0d", i), 32'(obs_winner), 32'(exp_order[i]));
    end
    r0_req = 1'b0; r1_req = 1'b0;

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      if (!r0_req && $urandom_range(0, 1) == 1) begin
        r0_req = 1'b1; r0_we = 1'($urandom_range(0, 1)); r0_addr = $urandom; r0_wdata = $urandom;
      end
      if (!r1_req && $urandom_range(0, 1) == 1) begin
        r1_req = 1'b1; r1_we = 1'($urandom_range(0, 1)); r1_addr = $urandom; r1_wdata = $urandom;
      end
      if (!r0_req && !r1_req) begin
        step();
        chk_outs("idle_gap", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        r0_req = 1'b1; r0_we = 1'($urandom_range(0, 1)); r0_addr = $urandom; r0_wdata = $urandom;
      end
      for (int k = 0; k < 4; k++) din_bytes[k] = 8'($urandom_range(0, 255));
      run_one(1'b0, $urandom_range(0, 3) == 0);
    end
    while (r0_req || r1_req) run_one(1'b0, 1'b0);

    // Make sure rdata holds something non-zero before the reset check
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = $urandom;
    din_bytes = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    run_one(1'b0, 1'b0);

    // Reset during A2 of a tie
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = $urandom; r0_wdata = $urandom;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = $urandom; r1_wdata = $urandom;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("abort_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("abort_reset.rdata", rdata, 32'h0);
    last_served = (TB_RR_INIT == 0) ? 1 : 0;
    model_rdata = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk_outs("in_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    rst_n = 1'b1;
    step();
    chk_outs("after_abort", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    r0_req = 1'b1; r1_req = 1'b1;
    run_one(1'b0, 1'b0);
    check("post_reset_tie", 32'(obs_winner), 32'(TB_RR_INIT));
    while (r0_req || r1_req) run_one(1'b0, 1'b0);

`ifdef SEQ_WAIT_EN
    // Stall three cycles in R1
    wait_r1_en = 1'b1;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = $urandom;
    din_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_one(1'b0, 1'b0);
    check("wait_rdata", rdata, 32'h44332211);
    wait_r1_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
